flash_loader: RTL

// - Boot-time copy engine upstream of the QSPI flash controller: Wishbone master reading N
//   32-bit words from flash, writing them in order to a destination Wishbone slave (RAM/ROM shadow).
// - Overlaps flash reads (~70 clk each) with destination writes via a 2-word buffer; one

---
 rtl/flash_loader_pkg.sv | 13 +
 rtl/loader_fifo2.sv | 46 ++++
 rtl/flash_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/flash_loader_pkg.sv
// Shared types and constants for the boot-time flash-to-RAM copy engine.
package flash_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    localparam int FLASH_AW   = 28;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/loader_fifo2.sv
// Two-entry word buffer between the flash read side and the destination write side.
module loader_fifo2 (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] din_i,
    output logic [31:0] head_o,
    output logic        full_o,
    output logic        empty_o
);

    logic [31:0] mem_q [0:1];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  cnt_q;
    logic        do_push;
    logic        do_pop;

    assign do_push = push_i && (cnt_q != 2'd2);
    assign do_pop  = pop_i && (cnt_q != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/flash_loader.sv
// Copies N words from QSPI flash to a destination Wishbone slave, overlapping the slow
// flash reads with destination writes through a two-word buffer.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int DST_AW = 24,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [0:27]       src_adr,
    input  logic [DST_AW-1:0] dst_adr,
    input  logic [LEN_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [0:27]       f_adr_o,
    output logic              f_cyc_o,
    output logic              f_stb_o,
    output logic              f_we_o,
    output logic [3:0]        f_sel_o,
    input  logic [0:31]       f_dat_i,
    input  logic              f_ack_i,
    output logic [DST_AW-1:0] d_adr_o,
    output logic [0:31]       d_dat_o,
    output logic              d_cyc_o,
    output logic              d_stb_o,
    output logic              d_we_o,
    output logic [3:0]        d_sel_o,
    input  logic              d_ack_i
);

    state_e              state_q;
    logic [0:27]         src_q;
    logic [DST_AW-1:0]   dst_q;
    logic [LEN_W-1:0]    rd_left_q;
    logic [LEN_W-1:0]    wr_left_q;
    logic                busy_q;
    logic                done_q;
    logic                f_stb_q;
    logic                d_stb_q;

    logic                f_ack_ok;
    logic                d_ack_ok;
    logic                rd_issue;
    logic                wr_issue;
    logic [31:0]         fifo_head;
    logic                fifo_full;
    logic                fifo_empty;

    // Acks arriving without an outstanding strobe (e.g. a late ack after reset) are dropped here.
    assign f_ack_ok = f_stb_q && f_ack_i;
    assign d_ack_ok = d_stb_q && d_ack_i;
    assign rd_issue = (state_q == ST_RUN) && !f_stb_q && (rd_left_q != '0) && !fifo_full;
    assign wr_issue = (state_q == ST_RUN) && !d_stb_q && !fifo_empty;

    loader_fifo2 u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (f_ack_ok),
        .pop_i   (d_ack_ok),
        .din_i   (f_dat_i),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rd_left_q <= '0;
            wr_left_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            f_stb_q   <= 1'b0;
            d_stb_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        src_q     <= src_adr & ~28'h3;
                        dst_q     <= dst_adr & ~DST_AW'(3);
                        rd_left_q <= count;
                        wr_left_q <= count;
                        if (count == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (rd_issue) begin
                        f_stb_q <= 1'b1;
                    end else if (f_ack_ok) begin
                        f_stb_q   <= 1'b0;
                        src_q     <= src_q + 28'(WORD_BYTES);
                        rd_left_q <= rd_left_q - 1'b1;
                    end
                    if (wr_issue) begin
                        d_stb_q <= 1'b1;
                    end else if (d_ack_ok) begin
                        d_stb_q   <= 1'b0;
                        dst_q     <= dst_q + DST_AW'(WORD_BYTES);
                        wr_left_q <= wr_left_q - 1'b1;
                        if (wr_left_q == LEN_W'(1)) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign f_adr_o = src_q;
    assign f_cyc_o = f_stb_q;
    assign f_stb_o = f_stb_q;
    assign f_we_o  = 1'b0;
    assign f_sel_o = 4'b1111;
    assign d_adr_o = dst_q;
    assign d_dat_o = fifo_head;
    assign d_cyc_o = d_stb_q;
    assign d_stb_o = d_stb_q;
    assign d_we_o  = d_stb_q;
    assign d_sel_o = 4'b1111;

endmodule
